// File: rtl/sys_defs.sv
// Shared CDB definitions used by the requester, RS, ROB and map table.
package sys_defs;

    localparam int CDB_TAG_W  = 6;
    localparam int CDB_DATA_W = 64;

    typedef struct packed {
        logic                  valid;
        logic [CDB_TAG_W-1:0]  tag;
        logic [CDB_DATA_W-1:0] data;
    } cdb_packet_t;

endpackage

// File: rtl/onehot_idx_enc.sv
// Highest-set-bit index encoder with a multi-hot flag.
module onehot_idx_enc #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     vec,
    output logic [IDX_W-1:0] idx,
    output logic             any,
    output logic             multi
);

    // Scan upward so the highest set bit is the last one written to idx.
    always_comb begin
        idx   = '0;
        any   = 1'b0;
        multi = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (vec[i]) begin
                multi = multi | any;
                any   = 1'b1;
                idx   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/cdb_requester.sv
// Requester side of the CDB handshake: holds one result per source, requests
// the bus, and broadcasts the granted slot on a registered CDB.
module cdb_requester
    import sys_defs::*;
#(
    parameter int NUM_SRC = 4,
    parameter int TAG_W   = CDB_TAG_W,
    parameter int DATA_W  = CDB_DATA_W
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_SRC-1:0]        src_valid,
    input  logic [NUM_SRC*TAG_W-1:0]  src_tag,
    input  logic [NUM_SRC*DATA_W-1:0] src_data,
    output logic [NUM_SRC-1:0]        src_ready,
    output logic [NUM_SRC-1:0]        req,
    output logic                      req_en,
    input  logic [NUM_SRC-1:0]        gnt,
    output logic                      cdb_valid,
    output logic [TAG_W-1:0]          cdb_tag,
    output logic [DATA_W-1:0]         cdb_data,
    output logic                      protocol_err
);

    localparam int IDX_W = $clog2(NUM_SRC);

    logic [NUM_SRC-1:0] held;
    logic [NUM_SRC-1:0] held_next;
    logic [NUM_SRC-1:0] g_ok;
    logic [NUM_SRC-1:0] capture;
    logic [NUM_SRC-1:0] retire;
    logic [TAG_W-1:0]   tag_q  [NUM_SRC];
    logic [DATA_W-1:0]  data_q [NUM_SRC];
    logic [IDX_W-1:0]   win_idx;
    logic               win_any;
    logic               win_multi;

    assign g_ok      = gnt & held;
    assign src_ready = ~held | g_ok;
    assign req       = held;
    assign req_en    = |held;
    assign capture   = src_valid & src_ready;

    onehot_idx_enc #(
        .N     (NUM_SRC),
        .IDX_W (IDX_W)
    ) u_win_enc (
        .vec   (g_ok),
        .idx   (win_idx),
        .any   (win_any),
        .multi (win_multi)
    );

    // Only the winning granted slot retires; capture overrides retire.
    always_comb begin
        retire    = win_any ? (NUM_SRC'(1) << win_idx) : '0;
        held_next = held;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (capture[i]) begin
                held_next[i] = 1'b1;
            end else if (retire[i]) begin
                held_next[i] = 1'b0;
            end
        end
    end

    // Held bits, cleared by reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            held <= '0;
        end else begin
            held <= held_next;
        end
    end

    // Slot payload registers load on capture and need no reset.
    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_SRC; i++) begin
            if (capture[i]) begin
                tag_q[i]  <= src_tag[i*TAG_W +: TAG_W];
                data_q[i] <= src_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Registered broadcast from the stored values of the winning slot.
    always_ff @(posedge clock) begin
        if (reset) begin
            cdb_valid <= 1'b0;
            cdb_tag   <= '0;
            cdb_data  <= '0;
        end else if (win_any) begin
            cdb_valid <= 1'b1;
            cdb_tag   <= tag_q[win_idx];
            cdb_data  <= data_q[win_idx];
        end else begin
            cdb_valid <= 1'b0;
        end
    end

    // Sticky flag for grants to empty slots or multi-bit grants; a multi-bit
    // grant with any empty bit is already caught by the first term.
    always_ff @(posedge clock) begin
        if (reset) begin
            protocol_err <= 1'b0;
        end else if ((|(gnt & ~held)) || win_multi) begin
            protocol_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cdb_requester.sv
// Self-checking bench for cdb_requester against a slot-level reference model.
module tb_cdb_requester;

    localparam int NUM_SRC = 4;
    localparam int TAG_W   = 6;
    localparam int DATA_W  = 64;

    logic                      clock = 1'b0;
    logic                      reset;
    logic [NUM_SRC-1:0]        src_valid;
    logic [NUM_SRC*TAG_W-1:0]  src_tag;
    logic [NUM_SRC*DATA_W-1:0] src_data;
    logic [NUM_SRC-1:0]        src_ready;
    logic [NUM_SRC-1:0]        req;
    logic                      req_en;
    logic [NUM_SRC-1:0]        gnt;
    logic                      cdb_valid;
    logic [TAG_W-1:0]          cdb_tag;
    logic [DATA_W-1:0]         cdb_data;
    logic                      protocol_err;

    int errors = 0;
    int checks = 0;

    // Reference model: what each slot holds and what the bus should show.
    logic [NUM_SRC-1:0] held_m;
    logic [TAG_W-1:0]   tag_m  [NUM_SRC];
    logic [DATA_W-1:0]  data_m [NUM_SRC];
    logic               cdb_v_m;
    logic [TAG_W-1:0]   cdb_t_m;
    logic [DATA_W-1:0]  cdb_d_m;
    logic               err_m;

    cdb_requester #(.NUM_SRC(NUM_SRC), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
        .clock(clock), .reset(reset), .src_valid(src_valid), .src_tag(src_tag),
        .src_data(src_data), .src_ready(src_ready), .req(req), .req_en(req_en),
        .gnt(gnt), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .protocol_err(protocol_err)
    );

    always #5 clock = ~clock;

    // A slot accepts when it is empty or when it is being granted right now.
    function automatic logic [NUM_SRC-1:0] exp_ready();
        logic [NUM_SRC-1:0] r;
        for (int i = 0; i < NUM_SRC; i++) r[i] = !held_m[i] || (gnt[i] && held_m[i]);
        return r;
    endfunction

    task automatic set_src(input int i, input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d);
        src_tag[i*TAG_W +: TAG_W]    = t;
        src_data[i*DATA_W +: DATA_W] = d;
    endtask

    task automatic to_negedge();
        @(negedge clock);
        reset = 1'b0; src_valid = '0; gnt = '0;
    endtask

    // Advance the model by one edge using the inputs currently driven, then
    // clock the DUT and settle just after the edge.
    task automatic tick();
        int w;
        logic [NUM_SRC-1:0] rdy;
        w   = -1;
        rdy = exp_ready();
        for (int i = 0; i < NUM_SRC; i++) if (gnt[i] && held_m[i]) w = i;
        if (reset) begin
            held_m = '0; cdb_v_m = 1'b0; cdb_t_m = '0; cdb_d_m = '0; err_m = 1'b0;
        end else begin
            if ((gnt & ~held_m) != '0 || $countones(gnt) > 1) err_m = 1'b1;
            if (w >= 0) begin
                cdb_v_m = 1'b1; cdb_t_m = tag_m[w]; cdb_d_m = data_m[w];
            end else begin
                cdb_v_m = 1'b0;
            end
            for (int i = 0; i < NUM_SRC; i++) begin
                if (src_valid[i] && rdy[i]) begin
                    held_m[i] = 1'b1;
                    tag_m[i]  = src_tag[i*TAG_W +: TAG_W];
                    data_m[i] = src_data[i*DATA_W +: DATA_W];
                end else if (i == w) begin
                    held_m[i] = 1'b0;
                end
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        to_negedge(); reset = 1'b1; tick();
        to_negedge(); #1;
        checks++;
        if ({cdb_valid, req, req_en, protocol_err, src_ready} !== {1'b0, 4'b0000, 1'b0, 1'b0, 4'b1111}) begin
            errors++;
            $display("[TB] FAIL reset_idle actual v=%b req=%b en=%b err=%b rdy=%b required v=0 req=0000 en=0 err=0 rdy=1111",
                     cdb_valid, req, req_en, protocol_err, src_ready);
        end
        checks++;
        if ({cdb_tag, cdb_data} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_bus actual tag=%h data=%h required zero", cdb_tag, cdb_data);
        end
    endtask

    task automatic test_single();
        to_negedge(); src_valid = 4'b0010; set_src(1, 6'h05, 64'hAB); tick();
        to_negedge(); gnt = 4'b0010; #1;
        checks++;
        if ({req, req_en} !== {4'b0010, 1'b1}) begin
            errors++; $display("[TB] FAIL single_req actual=%b/%b required=0010/1", req, req_en);
        end
        tick();
        checks++;
        if ({cdb_valid, cdb_tag, cdb_data} !== {1'b1, 6'h05, 64'hAB}) begin
            errors++;
            $display("[TB] FAIL single_bus actual v=%b tag=%h data=%h required v=1 tag=05 data=ab", cdb_valid, cdb_tag, cdb_data);
        end
        to_negedge(); tick();
        checks++;
        if ({cdb_valid, req} !== {1'b0, 4'b0000}) begin
            errors++; $display("[TB] FAIL single_after actual v=%b req=%b required v=0 req=0000", cdb_valid, req);
        end
    endtask

    task automatic test_contention();
        to_negedge(); src_valid = 4'b1001; set_src(0, 6'h0A, 64'h1000); set_src(3, 6'h3C, 64'h3000); tick();
        to_negedge(); gnt = 4'b1000; #1;
        checks++;
        if (req !== 4'b1001) begin errors++; $display("[TB] FAIL cont_req0 actual=%b required=1001", req); end
        tick();
        checks++;
        if ({cdb_valid, cdb_tag, cdb_data, req} !== {1'b1, 6'h3C, 64'h3000, 4'b0001}) begin
            errors++; $display("[TB] FAIL cont_first actual v=%b tag=%h req=%b required v=1 tag=3c req=0001", cdb_valid, cdb_tag, req);
        end
        to_negedge(); gnt = 4'b0001; tick();
        checks++;
        if ({cdb_valid, cdb_tag, cdb_data, req} !== {1'b1, 6'h0A, 64'h1000, 4'b0000}) begin
            errors++; $display("[TB] FAIL cont_second actual v=%b tag=%h req=%b required v=1 tag=0a req=0000", cdb_valid, cdb_tag, req);
        end
        to_negedge(); tick();
    endtask

    task automatic test_refill();
        to_negedge(); src_valid = 4'b0100; set_src(2, 6'h22, 64'hDEAD); tick();
        to_negedge(); src_valid = 4'b0100; gnt = 4'b0100; set_src(2, 6'h11, 64'hBEEF); #1;
        checks++;
        if (src_ready[2] !== 1'b1) begin errors++; $display("[TB] FAIL refill_ready actual=%b required=1", src_ready[2]); end
        tick();
        checks++;
        if ({cdb_valid, cdb_tag, cdb_data, req[2]} !== {1'b1, 6'h22, 64'hDEAD, 1'b1}) begin
            errors++; $display("[TB] FAIL refill_old actual v=%b tag=%h held2=%b required v=1 tag=22 held2=1", cdb_valid, cdb_tag, req[2]);
        end
        to_negedge(); gnt = 4'b0100; tick();
        checks++;
        if ({cdb_valid, cdb_tag, cdb_data} !== {1'b1, 6'h11, 64'hBEEF}) begin
            errors++; $display("[TB] FAIL refill_new actual v=%b tag=%h data=%h required v=1 tag=11 data=beef", cdb_valid, cdb_tag, cdb_data);
        end
    endtask

    task automatic test_backpressure();
        to_negedge(); src_valid = 4'b1111;
        for (int i = 0; i < NUM_SRC; i++) set_src(i, 6'(8 + i), 64'(100 + i));
        tick();
        for (int c = 0; c < 3; c++) begin
            to_negedge(); src_valid = 4'b1111;
            for (int i = 0; i < NUM_SRC; i++) set_src(i, 6'h3F, 64'hFFFF);
            #1;
            checks++;
            if (src_ready !== 4'b0000) begin errors++; $display("[TB] FAIL bp_ready actual=%b required=0000", src_ready); end
            tick();
            checks++;
            if (cdb_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_idle actual=%b required=0", cdb_valid); end
        end
        // Drain from the top, confirming the originally stored values.
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            to_negedge(); gnt = NUM_SRC'(1) << i; tick();
            checks++;
            if ({cdb_valid, cdb_tag, cdb_data} !== {1'b1, 6'(8 + i), 64'(100 + i)}) begin
                errors++; $display("[TB] FAIL bp_drain%0d actual v=%b tag=%h data=%h required v=1 tag=%h data=%h",
                                   i, cdb_valid, cdb_tag, cdb_data, 6'(8 + i), 64'(100 + i));
            end
        end
    endtask

    task automatic test_protocol();
        to_negedge(); src_valid = 4'b0001; set_src(0, 6'h07, 64'h77); tick();
        to_negedge(); gnt = 4'b0100; tick();
        checks++;
        if ({protocol_err, req, cdb_valid} !== {1'b1, 4'b0001, 1'b0}) begin
            errors++; $display("[TB] FAIL proto_set actual err=%b req=%b v=%b required err=1 req=0001 v=0", protocol_err, req, cdb_valid);
        end
        to_negedge(); tick();
        checks++;
        if (protocol_err !== 1'b1) begin errors++; $display("[TB] FAIL proto_sticky actual=%b required=1", protocol_err); end
        // Reset while a grant is offered: nothing broadcasts, everything drops.
        to_negedge(); reset = 1'b1; gnt = 4'b0001; tick();
        checks++;
        if ({protocol_err, req, cdb_valid} !== {1'b0, 4'b0000, 1'b0}) begin
            errors++; $display("[TB] FAIL proto_reset actual err=%b req=%b v=%b required err=0 req=0000 v=0", protocol_err, req, cdb_valid);
        end
        // Multi-bit grant on two held slots: highest wins, other stays held.
        to_negedge(); src_valid = 4'b0011; set_src(0, 6'h01, 64'h10); set_src(1, 6'h02, 64'h20); tick();
        to_negedge(); gnt = 4'b0011; tick();
        checks++;
        if ({protocol_err, cdb_valid, cdb_tag, req} !== {1'b1, 1'b1, 6'h02, 4'b0001}) begin
            errors++; $display("[TB] FAIL proto_multi actual err=%b v=%b tag=%h req=%b required err=1 v=1 tag=02 req=0001",
                               protocol_err, cdb_valid, cdb_tag, req);
        end
        to_negedge(); reset = 1'b1; tick();
    endtask

    task automatic test_random();
        int w;
        for (int c = 0; c < 300; c++) begin
            to_negedge();
            src_valid = NUM_SRC'($urandom);
            for (int i = 0; i < NUM_SRC; i++) set_src(i, 6'($urandom), {$urandom, $urandom});
            w = -1;
            for (int i = 0; i < NUM_SRC; i++) if (held_m[i]) w = i;
            if (w >= 0 && $urandom_range(3, 0) != 0) gnt = NUM_SRC'(1) << w;
            #1;
            checks++;
            if ({req, req_en, src_ready} !== {held_m, |held_m, exp_ready()}) begin
                errors++; $display("[TB] FAIL rand_comb c=%0d actual req=%b en=%b rdy=%b required req=%b en=%b rdy=%b",
                                   c, req, req_en, src_ready, held_m, |held_m, exp_ready());
            end
            tick();
            checks++;
            if ({cdb_valid, cdb_tag, cdb_data, protocol_err} !== {cdb_v_m, cdb_t_m, cdb_d_m, err_m}) begin
                errors++; $display("[TB] FAIL rand_bus c=%0d actual v=%b tag=%h data=%h err=%b required v=%b tag=%h data=%h err=%b",
                                   c, cdb_valid, cdb_tag, cdb_data, protocol_err, cdb_v_m, cdb_t_m, cdb_d_m, err_m);
            end
        end
    endtask

    initial begin
        reset = 1'b1; src_valid = '0; gnt = '0; src_tag = '0; src_data = '0;
        held_m = '0; cdb_v_m = 1'b0; cdb_t_m = '0; cdb_d_m = '0; err_m = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin tag_m[i] = '0; data_m[i] = '0; end
        test_reset();
        test_single();
        test_contention();
        test_refill();
        test_backpressure();
        test_protocol();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
